// File: rtl/tmboc_acq_corr.sv
// Coherent I/Q correlator against the local TMBOC replica.
// Accumulates over ncoh code periods and dumps saturated sums plus a magnitude estimate.
//
// state    | meaning
// IDLE     | disarmed, waiting for rx_start
// WAIT_SOP | armed, waiting for the first sample of a code period
// ACC      | accumulating products until the last period's eop
// DUMP     | one cycle: register sums, magnitude and ovf to the outputs
module tmboc_acq_corr #(
    parameter int IN_WIDTH   = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int NCOH_WIDTH = 4
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  rx_start,
    input  logic [IN_WIDTH-1:0]   rx_i,
    input  logic [IN_WIDTH-1:0]   rx_q,
    input  logic                  rx_loc_tmboc,
    input  logic                  rx_prn_sop,
    input  logic                  rx_prn_eop,
    input  logic [NCOH_WIDTH-1:0] rx_ncoh,
    output logic [ACC_WIDTH-1:0]  tx_corr_i,
    output logic [ACC_WIDTH-1:0]  tx_corr_q,
    output logic [ACC_WIDTH-1:0]  tx_corr_mag,
    output logic                  tx_corr_valid,
    output logic                  tx_corr_ovf,
    output logic                  tx_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOP, S_ACC, S_DUMP} state_t;

    localparam logic signed [ACC_WIDTH:0] SAT_POS = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_NEG = -SAT_POS;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc_i, acc_q;
    logic                   acc_ovf;
    logic [NCOH_WIDTH-1:0]  period_cnt, ncoh_eff, ncoh_in;
    logic                   acc_load, acc_add, cnt_inc, dump, last_period;
    logic [ACC_WIDTH-1:0]   ext_i, ext_q, prod_i, prod_q;
    logic [ACC_WIDTH:0]     sum_i, sum_q;
    logic [ACC_WIDTH-1:0]   abs_i, abs_q, mag_big, mag_small, mag;

    // Result MSB flags a clip; the sum is clamped symmetrically so |x| fits in ACC_WIDTH-1 bits.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        s = $signed({a[ACC_WIDTH-1], a}) + $signed({b[ACC_WIDTH-1], b});
        if (s > SAT_POS)
            return {1'b1, SAT_POS[ACC_WIDTH-1:0]};
        else if (s < SAT_NEG)
            return {1'b1, SAT_NEG[ACC_WIDTH-1:0]};
        else
            return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    assign ext_i  = {{(ACC_WIDTH-IN_WIDTH){rx_i[IN_WIDTH-1]}}, rx_i};
    assign ext_q  = {{(ACC_WIDTH-IN_WIDTH){rx_q[IN_WIDTH-1]}}, rx_q};
    assign prod_i = rx_loc_tmboc ? -ext_i : ext_i;
    assign prod_q = rx_loc_tmboc ? -ext_q : ext_q;
    assign sum_i  = sat_add(acc_i, prod_i);
    assign sum_q  = sat_add(acc_q, prod_q);

    assign ncoh_in     = (rx_ncoh == '0) ? NCOH_WIDTH'(1) : rx_ncoh;
    assign last_period = (period_cnt + NCOH_WIDTH'(1)) == ncoh_eff;

    assign abs_i     = acc_i[ACC_WIDTH-1] ? -acc_i : acc_i;
    assign abs_q     = acc_q[ACC_WIDTH-1] ? -acc_q : acc_q;
    assign mag_big   = (abs_i >= abs_q) ? abs_i : abs_q;
    assign mag_small = (abs_i >= abs_q) ? abs_q : abs_i;
    assign mag       = mag_big + (mag_small >> 1);

    assign tx_busy = (state != S_IDLE);

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        cnt_inc   = 1'b0;
        dump      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_start)
                    state_nxt = S_WAIT_SOP;
            end
            S_WAIT_SOP: begin
                if (rx_prn_sop) begin
                    acc_load  = 1'b1;
                    state_nxt = (rx_prn_eop && ncoh_in == NCOH_WIDTH'(1)) ? S_DUMP : S_ACC;
                end
            end
            S_ACC: begin
                acc_add = 1'b1;
                if (rx_prn_eop) begin
                    if (last_period)
                        state_nxt = S_DUMP;
                    else
                        cnt_inc = 1'b1;
                end
            end
            S_DUMP: begin
                dump      = 1'b1;
                state_nxt = rx_start ? S_WAIT_SOP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            acc_i      <= '0;
            acc_q      <= '0;
            acc_ovf    <= 1'b0;
            period_cnt <= '0;
            ncoh_eff   <= NCOH_WIDTH'(1);
        end else if (acc_load) begin
            acc_i      <= prod_i;
            acc_q      <= prod_q;
            acc_ovf    <= 1'b0;
            ncoh_eff   <= ncoh_in;
            // A sop coinciding with eop has already completed one period.
            period_cnt <= rx_prn_eop ? NCOH_WIDTH'(1) : '0;
        end else if (acc_add) begin
            acc_i   <= sum_i[ACC_WIDTH-1:0];
            acc_q   <= sum_q[ACC_WIDTH-1:0];
            acc_ovf <= acc_ovf | sum_i[ACC_WIDTH] | sum_q[ACC_WIDTH];
            if (cnt_inc)
                period_cnt <= period_cnt + NCOH_WIDTH'(1);
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            tx_corr_i     <= '0;
            tx_corr_q     <= '0;
            tx_corr_mag   <= '0;
            tx_corr_ovf   <= 1'b0;
            tx_corr_valid <= 1'b0;
        end else begin
            tx_corr_valid <= dump;
            if (dump) begin
                tx_corr_i   <= acc_i;
                tx_corr_q   <= acc_q;
                tx_corr_mag <= mag;
                tx_corr_ovf <= acc_ovf;
            end
        end
    end

endmodule
